// File: rtl/sd_fifo_pkg.sv
// Shared constants and helpers for the SD host stream FIFO.
// Holds the default almost-full margin and the level/pointer width rule.
package sd_fifo_pkg;

  localparam int AF_MARGIN_DEFAULT = 4;

  // The level counts 0..2**depth_log2 inclusive, so it needs one extra bit over a pointer.
  function automatic int level_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/sd_fifo_ram.sv
// Simple dual-port storage for the stream FIFO.
// One write port and one registered read port with a read enable; no reset.
module sd_fifo_ram #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset branch so it maps onto block RAM; the control
  // logic never reads a location that has not been written since reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_stream_fifo.sv
// First-word-fall-through AXI-Stream FIFO for the SD host data path.
// Registered-read RAM feeds a prefetch stage, which feeds one registered output stage.
module sd_stream_fifo
  import sd_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 9,
  parameter int AF_MARGIN  = AF_MARGIN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn_in,
  input  logic [WIDTH-1:0]      in_tdata,
  input  logic                  in_tlast,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [WIDTH-1:0]      out_tdata,
  output logic                  out_tlast,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  almostfull,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   blocks
);

  localparam int LW    = level_width(DEPTH_LOG2);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] AF_THRESH = LW'(DEPTH - AF_MARGIN);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         ram_cnt_q, ram_cnt_d;
  logic [LW-1:0]         level_q, level_d;
  logic [LW-1:0]         blocks_q, blocks_d;
  logic                  ram_valid_q, ram_valid_d;
  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_data_q;
  logic                  out_last_q;
  logic                  in_ready_q;
  logic                  almostfull_q;

  logic                  wr_en, rd_fire, load_out, ram_re;
  logic [WIDTH:0]        ram_rdata;

  // ram_cnt counts words written but not yet read out of the RAM. Reading only when it
  // is non-zero keeps the read address off the write address: when all DEPTH words
  // sit in the RAM, level is DEPTH and in_tready is already low.
  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    wr_en       = in_tvalid & in_ready_q;
    rd_fire     = out_valid_q & out_tready;
    load_out    = ram_valid_q & (~out_valid_q | rd_fire);
    ram_re      = (ram_cnt_q != '0) & (~ram_valid_q | load_out);
    ram_valid_d = ram_re | (ram_valid_q & ~load_out);

    wr_ptr_d = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + 1'b1 : rd_ptr_q;

    ram_cnt_d = ram_cnt_q;
    unique case ({wr_en, ram_re})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    level_d = level_q;
    unique case ({wr_en, rd_fire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    blocks_d = blocks_q;
    unique case ({wr_en & in_tlast, rd_fire & out_last_q})
      2'b10:   blocks_d = blocks_q + 1'b1;
      2'b01:   blocks_d = blocks_q - 1'b1;
      default: blocks_d = blocks_q;
    endcase
  end

  sd_fifo_ram #(
    .WIDTH  (WIDTH + 1),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_tlast, in_tdata}),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      level_q      <= '0;
      blocks_q     <= '0;
      ram_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      almostfull_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      level_q      <= level_d;
      blocks_q     <= blocks_d;
      ram_valid_q  <= ram_valid_d;
      in_ready_q   <= (level_d < DEPTH_L);
      almostfull_q <= (level_q >= AF_THRESH);
      if (load_out) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ram_rdata[WIDTH-1:0];
        out_last_q  <= ram_rdata[WIDTH];
      end else if (rd_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_tready  = in_ready_q;
  assign out_tvalid = out_valid_q;
  assign out_tdata  = out_data_q;
  assign out_tlast  = out_last_q;
  assign almostfull = almostfull_q;
  assign level      = level_q;
  assign blocks     = blocks_q;

endmodule

// File: doc/sd_stream_fifo.md
SD_STREAM_FIFO -- requirements
Module: sd_stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits, matching the SD host data stream width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9, meaning the capacity is 2**DEPTH_LOG2 words (512, one SD block at WIDTH=8).
REQ-003 SHALL have parameter AF_MARGIN, default 4, meaning almostfull asserts when free space is AF_MARGIN words or less.
REQ-004 SHALL have port clk, input, width 1, meaning the single clock for all logic.
REQ-005 SHALL have port resetn_in, input, width 1, meaning reset: asynchronous, active-low; driven from the SD host fifo_in_resetn/fifo_out_resetn.
REQ-006 SHALL have ports in_tdata (input, WIDTH), in_tlast (input, 1), in_tvalid (input, 1) and in_tready (output, 1), forming the write-side AXI-Stream slave.
REQ-007 SHALL have ports out_tdata (output, WIDTH), out_tlast (output, 1), out_tvalid (output, 1) and out_tready (input, 1), forming the read-side AXI-Stream master.
REQ-008 SHALL have port almostfull, output, width 1, meaning a registered early back-pressure flag for the SD host read path.
REQ-009 SHALL have port level, output, width DEPTH_LOG2+1, meaning the count of words held, including the output stage.
REQ-010 SHALL have port blocks, output, width DEPTH_LOG2+1, meaning the count of complete blocks (words with tlast) held.

Function
REQ-011 SHALL perform a write on a clk edge with in_tvalid&in_tready, and a read on a clk edge with out_tvalid&out_tready.
REQ-012 SHALL drive in_tready = (level < 2**DEPTH_LOG2), registered; at full, in_tvalid SHALL be ignored and no data lost or overwritten.
REQ-013 SHALL store tlast alongside each data word; out_tlast SHALL accompany the same word it entered with.
REQ-014 SHALL present data first-word-fall-through through one registered output stage fed from a registered-read RAM.
REQ-015 SHALL assert out_tvalid exactly 2 clk cycles after the write edge of a word entering an empty FIFO.
REQ-016 SHALL keep out_tdata/out_tlast stable while out_tvalid=1 and out_tready=0.
REQ-017 SHALL sustain one read per cycle with out_tready=1 and data present, with no bubbles.
REQ-018 SHALL update level by +1 on a write only, -1 on a read only, and leave it unchanged on a simultaneous write and read.
REQ-019 SHALL update blocks by +1 on a write with in_tlast only, -1 on a read with out_tlast only, and leave it unchanged when both occur.
REQ-020 SHALL wrap the read and write pointers (DEPTH_LOG2 bits) modulo 2**DEPTH_LOG2 with no gap or repeat.
REQ-021 SHALL register almostfull = (level >= 2**DEPTH_LOG2 - AF_MARGIN), updated one cycle after level changes.
REQ-022 SHALL, when empty, allow a simultaneous write and out_tready=1 without a read occurring (out_tvalid=0 that cycle).
REQ-023 SHALL treat a RAM read and write to the same address in one cycle as impossible, by construction of the prefetch logic.

Reset
REQ-024 SHALL, while resetn_in=0, hold in_tready=0, out_tvalid=0, out_tlast=0, out_tdata=0, almostfull=0, level=0 and blocks=0, with both pointers at 0.
REQ-025 SHALL discard all contents on reset assertion, including in mid-stream; RAM contents need not be cleared.
REQ-026 SHALL raise in_tready on the first clk edge after resetn_in deasserts.

Structure
REQ-027 SHALL keep storage in a sub-module sd_fifo_ram: simple dual-port, one registered read port, one write port, no reset.
REQ-028 SHALL place the pointer/level width function and AF_MARGIN default in shared package sd_fifo_pkg; no typedefs are required.
REQ-029 SHALL contain no clock-domain crossing; all flops SHALL be on clk.

Verification
REQ-030 Fill/drain (DEPTH_LOG2=9): write 512 words 0..511 (mod 256) with tlast on the last -> in_tready=0 after word 512; level=512, blocks=1, almostfull=1 from level 508; drain -> identical order, out_tlast only on the 512th word.
REQ-031 Latency: single write of 0xA5 into an empty FIFO at edge E -> out_tvalid=1, out_tdata=0xA5 after edge E+2.
REQ-032 Streaming: in_tvalid=1 and out_tready=1 continuously for 2000 words -> throughput of 1 word/cycle after fill, level constant, pointers wrap 3 times with correct data.
REQ-033 Backpressure: out_tready random 30% with in_tvalid random 50% over 10000 words, with tlast every 512 -> scoreboard matches, blocks never negative and equal to the reference model count.
REQ-034 Full + simultaneous: at level=512 assert in_tvalid and out_tready together -> one read, no write; level=511, then in_tready=1 on the next cycle.
REQ-035 Reset mid-stream: assert resetn_in low at level=100 -> outputs zero immediately; after release, in_tready=1 and the first new word 0x3C emerges with no stale data.
